// File: rtl/tft_spi_receiver.sv
// Display-side SPI receiver: synchronizes SPI_CLK/MOSI/CS/RS into MasterCLK and rebuilds
// 16-bit words tagged with RS. Define TFT_RX_FIFO_EN to buffer words in a FifoDepth-entry FIFO.
module tft_spi_receiver #(
    parameter int WordBits   = 16,
    parameter int SyncStages = 2,
    parameter int FifoDepth  = 4
) (
    input  logic                MasterCLK,
    input  logic                RSTn,
    input  logic                SPI_CLK,
    input  logic                SPI_MOSI,
    input  logic                SPI_CS,
    input  logic                RS,
    input  logic                RxReady,
    input  logic                ClrErr,
    output logic [WordBits-1:0] RxData,
    output logic                RxRS,
    output logic                RxValid,
    output logic                Overrun,
    output logic                FrameErr,
    output logic                DbgState
);
    localparam int CntW = $clog2(WordBits) + 1;

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    logic [SyncStages-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync, r_rs_sync;
    logic [SyncStages:0]   r_fill;
    logic                  r_sclk_d, r_sclk_rise, r_mosi_e, r_rs_e, r_cs_e, r_cs_d;
    logic [WordBits-2:0]   r_shift;
    logic [CntW-1:0]       r_cnt;
    logic                  r_ferr, r_ovr;
    state_t                r_state, w_next;
    logic                  w_cs_fall, w_cs_rise, w_word_done, w_frame_evt, w_ovr_evt;
    logic [WordBits-1:0]   w_word;

    always_ff @(posedge MasterCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_rs_sync   <= '0;
            r_fill      <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SyncStages-2:0], SPI_CLK};
            r_mosi_sync <= {r_mosi_sync[SyncStages-2:0], SPI_MOSI};
            r_cs_sync   <= {r_cs_sync[SyncStages-2:0], SPI_CS};
            r_rs_sync   <= {r_rs_sync[SyncStages-2:0], RS};
            r_fill      <= {r_fill[SyncStages-1:0], 1'b1};
        end
    end

    // Edge stage; r_cs_d is held low until the chain has refilled so a CS already low at release is no edge.
    always_ff @(posedge MasterCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sclk_d    <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_mosi_e    <= 1'b0;
            r_rs_e      <= 1'b0;
            r_cs_e      <= 1'b1;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_d    <= r_sclk_sync[SyncStages-1];
            r_sclk_rise <= r_sclk_sync[SyncStages-1] & ~r_sclk_d;
            r_mosi_e    <= r_mosi_sync[SyncStages-1];
            r_rs_e      <= r_rs_sync[SyncStages-1];
            r_cs_e      <= r_cs_sync[SyncStages-1];
            r_cs_d      <= r_fill[SyncStages] ? r_cs_e : 1'b0;
        end
    end

    assign w_cs_fall = r_cs_d & ~r_cs_e;
    assign w_cs_rise = ~r_cs_d & r_cs_e;
    assign w_word    = {r_shift, r_mosi_e};

    always_ff @(posedge MasterCLK or negedge RSTn) begin
        if (!RSTn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_word_done = 1'b0;
        w_frame_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_cs_rise) begin
                    w_next      = S_IDLE;
                    w_frame_evt = (r_cnt != '0);
                end else if (r_sclk_rise && r_cnt == CntW'(WordBits - 1)) begin
                    w_word_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge MasterCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT && !w_cs_rise) begin
            if (r_sclk_rise) begin
                r_shift <= w_word[WordBits-2:0];
                r_cnt   <= w_word_done ? '0 : r_cnt + CntW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Sticky flags: a same-cycle error event wins over ClrErr.
    always_ff @(posedge MasterCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_frame_evt)  r_ferr <= 1'b1;
            else if (ClrErr)  r_ferr <= 1'b0;
            if (w_ovr_evt)    r_ovr  <= 1'b1;
            else if (ClrErr)  r_ovr  <= 1'b0;
        end
    end

`ifdef TFT_RX_FIFO_EN
    localparam int PtrW = $clog2(FifoDepth);

    logic [WordBits:0] r_mem [FifoDepth];
    logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PtrW:0]     r_count;
    logic              w_valid, w_full, w_pop, w_push;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == (PtrW+1)'(FifoDepth));
    assign w_pop     = w_valid & RxReady;
    assign w_push    = w_word_done & (~w_full | w_pop);
    assign w_ovr_evt = w_word_done & w_full & ~w_pop;

    always_ff @(posedge MasterCLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < FifoDepth; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_rs_e, w_word};
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PtrW+1)'(1);
                2'b01:   r_count <= r_count - (PtrW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign RxData  = r_mem[r_rd_ptr][WordBits-1:0];
    assign RxRS    = r_mem[r_rd_ptr][WordBits];
    assign RxValid = w_valid;
`else
    logic [WordBits-1:0] r_data;
    logic                r_rs, r_valid;

    assign w_ovr_evt = w_word_done & r_valid & ~RxReady;

    always_ff @(posedge MasterCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_word_done && !w_ovr_evt) begin
            r_data  <= w_word;
            r_rs    <= r_rs_e;
            r_valid <= 1'b1;
        end else if (r_valid && RxReady) begin
            r_valid <= 1'b0;
        end
    end

    assign RxData  = r_data;
    assign RxRS    = r_rs;
    assign RxValid = r_valid;
`endif

    assign Overrun  = r_ovr;
    assign FrameErr = r_ferr;
    assign DbgState = r_state;
endmodule

// File: tb/tb_tft_spi_receiver.sv
// Directed + randomized bench for tft_spi_receiver; word/flag expectations come from a
// capacity-based delivery model and an expected-word queue.
module tb_tft_spi_receiver;
    localparam int W    = 16;
    localparam int SYNC = 2;
`ifdef TFT_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic         MasterCLK = 1'b0;
    logic         RSTn, SPI_CLK, SPI_MOSI, SPI_CS, RS, RxReady, ClrErr;
    logic [W-1:0] RxData;
    logic         RxRS, RxValid, Overrun, FrameErr, DbgState;

    tft_spi_receiver #(.WordBits(W), .SyncStages(SYNC), .FifoDepth(4)) dut (
        .MasterCLK(MasterCLK), .RSTn(RSTn), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
        .SPI_CS(SPI_CS), .RS(RS), .RxReady(RxReady), .ClrErr(ClrErr),
        .RxData(RxData), .RxRS(RxRS), .RxValid(RxValid), .Overrun(Overrun),
        .FrameErr(FrameErr), .DbgState(DbgState)
    );

    always #5 MasterCLK = ~MasterCLK;

    int         vectors = 0;
    int         miscompares = 0;
    logic [W:0] exp_q[$];     // {rs, data}, oldest first
    logic       exp_ovr, exp_ferr;
    bit         mon_en;
    logic [W:0] mon_e, held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: a completed word is kept if fewer than CAP words are waiting, otherwise it is lost.
    task automatic push_word(input logic [W-1:0] d, input logic rs);
        if (exp_q.size() < CAP) exp_q.push_back({rs, d});
        else                    exp_ovr = 1'b1;
    endtask

    always @(negedge MasterCLK) begin
        if (mon_en && RxValid === 1'b1 && RxReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_data", 32'(RxData), 32'(mon_e[W-1:0]));
                check("rx_rs", 32'(RxRS), 32'(mon_e[W]));
            end
        end
    end

    task automatic settle();
        repeat (8) @(negedge MasterCLK);
    endtask

    task automatic set_ready(input logic v);
        @(posedge MasterCLK);
        #2 RxReady = v;
    endtask

    task automatic cs_set(input logic v);
        @(negedge MasterCLK);
        SPI_CS = v;
        repeat (6) @(negedge MasterCLK);
    endtask

    task automatic pulse_clr();
        @(negedge MasterCLK) ClrErr = 1'b1;
        @(negedge MasterCLK) ClrErr = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        @(negedge MasterCLK);
    endtask

    // mode 0: plain, 1: measure last-bit latency, 2: raise RxReady so the pop meets the word completion.
    task automatic send_word(input logic [W-1:0] d, input int nbits, input logic rs, input int mode);
        int  n;
        bit  seen;
        for (int i = 0; i < nbits; i++) begin
            @(negedge MasterCLK);
            SPI_MOSI = d[W-1-i];
            RS       = rs;
            repeat (2) @(negedge MasterCLK);
            if (i == nbits - 1 && nbits == W) begin
                if (mode == 2) held = exp_q.pop_front();
                push_word(d, rs);
            end
            @(negedge MasterCLK) SPI_CLK = 1'b1;
            if (i == nbits - 1 && mode == 1) begin
                n = 0;
                seen = 0;
                while (n < 12 && !seen) begin
                    @(posedge MasterCLK);
                    #1 n++;
                    if (RxValid === 1'b1) seen = 1;
                end
                check("latency_cycles", 32'(n), 32'(SYNC + 2));
            end else if (i == nbits - 1 && mode == 2) begin
                repeat (2) @(negedge MasterCLK);
                @(posedge MasterCLK);
                #2 RxReady = 1'b1;
                @(negedge MasterCLK);
                check("pop_prev_valid", 32'(RxValid), 32'd1);
                check("pop_prev_data", 32'(RxData), 32'(held[W-1:0]));
                @(negedge MasterCLK);
                check("pop_load_data", 32'(RxData), 32'(d));
                check("pop_load_rs", 32'(RxRS), 32'(rs));
                check("pop_load_ovr", 32'(Overrun), 32'(exp_ovr));
                RxReady = 1'b0;
            end
            repeat (3) @(negedge MasterCLK);
            SPI_CLK = 1'b0;
        end
    endtask

    task automatic drain();
        set_ready(1'b1);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge MasterCLK);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        settle();
        check("drain_valid", 32'(RxValid), 32'd0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovr"}, 32'(Overrun), 32'(exp_ovr));
        check({tag, "_ferr"}, 32'(FrameErr), 32'(exp_ferr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [W-1:0] d;
        logic         rs;
        RSTn = 1'b0; SPI_CLK = 1'b0; SPI_MOSI = 1'b0; SPI_CS = 1'b1; RS = 1'b0;
        RxReady = 1'b0; ClrErr = 1'b0; mon_en = 0; exp_ovr = 1'b0; exp_ferr = 1'b0;
        repeat (3) @(negedge MasterCLK);
        check("rst_valid", 32'(RxValid), 32'd0);
        check("rst_data", 32'(RxData), 32'd0);
        check("rst_rs", 32'(RxRS), 32'd0);
        check("rst_state", 32'(DbgState), 32'd0);
        check_flags("rst");
        RSTn = 1'b1;
        repeat (5) @(negedge MasterCLK);

        // Single word with latency measurement
        RxReady = 1'b1;
        mon_en  = 1;
        cs_set(1'b0);
        send_word(16'hA5C3, W, 1'b1, 1);
        settle();
        check("first_drained", 32'(exp_q.size()), 32'd0);
        check_flags("first");

        // Back-to-back stream under one CS-low window
        send_word(16'h002A, W, 1'b0, 0);
        send_word(16'h1234, W, 1'b1, 0);
        for (int k = 0; k < 8; k++) begin
            d  = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            send_word(d, W, rs, 0);
        end
        settle();
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check_flags("stream");

        // Consumer stalled: the model decides which words survive
        set_ready(1'b0);
        for (int k = 0; k < CAP + 2; k++) begin
            send_word(W'($urandom), W, 1'($urandom_range(0, 1)), 0);
            settle();
            check("stall_ovr", 32'(Overrun), 32'(exp_ovr));
            check("stall_head", 32'(RxData), 32'(exp_q[0][W-1:0]));
        end
        drain();
        check_flags("stall_after_drain");
        pulse_clr();
        check_flags("stall_clr");

        // Partial word then a full word
        send_word(W'($urandom), 7, 1'b0, 0);
        cs_set(1'b1);
        exp_ferr = 1'b1;
        check_flags("frame_partial");
        cs_set(1'b0);
        send_word(16'hFFFF, W, 1'b1, 0);
        settle();
        check("frame_drained", 32'(exp_q.size()), 32'd0);
        check_flags("frame_after_word");
        pulse_clr();
        check_flags("frame_clr");
        cs_set(1'b1);
        check_flags("cs_rise_aligned");
        cs_set(1'b0);

        // Word completion coinciding with a pop
        mon_en = 0;
        set_ready(1'b0);
        send_word(W'($urandom), W, 1'b0, 0);
        settle();
        send_word(W'($urandom), W, 1'b1, 2);
        settle();
        check_flags("pop_same_cycle");
        mon_en = 1;
        drain();

        // Reset in the middle of a word, CS still low at release
        send_word(W'($urandom), 9, 1'b1, 0);
        @(negedge MasterCLK) RSTn = 1'b0;
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        repeat (2) @(negedge MasterCLK);
        check("midrst_valid", 32'(RxValid), 32'd0);
        check("midrst_data", 32'(RxData), 32'd0);
        check_flags("midrst");
        RSTn = 1'b1;
        repeat (6) @(negedge MasterCLK);
        send_word(W'($urandom), 3, 1'b0, 0);
        settle();
        check("idle_after_rst", 32'(DbgState), 32'd0);
        cs_set(1'b1);
        check_flags("idle_cs_rise");
        cs_set(1'b0);
        send_word(16'h0F0F, W, 1'b0, 0);
        settle();
        check("rst_word_drained", 32'(exp_q.size()), 32'd0);
        check_flags("rst_word");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tft_spi_receiver.md
# tft_spi_receiver

Receive-side counterpart of the TFT SPI link: samples an incoming SPI_CLK / SPI_MOSI / SPI_CS / RS stream in the MasterCLK domain and reassembles it into 16-bit words tagged with their RS (command/data) level. Used as the display-side model in loopback benches and as the capture front end when a second board listens to the TFT bus. Received words are presented on a valid/ready interface with overrun and framing-error reporting.

## Interface
- WordBits, 16, bits per received word, MSB first
- SyncStages, 2, synchronizer flops per SPI input (≥2)
- FifoDepth, 4, entries when TFT_RX_FIFO_EN is defined (power of two)

- MasterCLK  input  1  system clock; all logic on its rising edge
- RSTn  input  1  asynchronous, active-low reset
- SPI_CLK  input  1  serial clock from transmitter, idle low, MOSI sampled on rising edge (mode 0)
- SPI_MOSI  input  1  serial data
- SPI_CS  input  1  chip select, active low
- RS  input  1  register-select level (0 command, 1 data)
- RxReady  input  1  consumer accepts word when RxValid & RxReady
- ClrErr  input  1  one-cycle pulse clears Overrun and FrameErr
- RxData  output  WordBits  received word
- RxRS  output  1  RS level captured with the word's last bit
- RxValid  output  1  word available
- Overrun  output  1  sticky: completed word dropped
- FrameErr  output  1  sticky: SPI_CS rose with 1..WordBits-1 bits shifted

## Operation
- SPI_CLK, SPI_MOSI, SPI_CS, RS each pass through SyncStages flops; reset values 0, 0, 1, 0.
- Edge detect on synchronized SPI_CLK: one-cycle sclk_rise pulse.
- States: IDLE (CS high), SHIFT (CS low). IDLE→SHIFT on synchronized CS falling; SHIFT→IDLE on CS rising.
- In SHIFT, each sclk_rise shifts MOSI into shift register (left shift, MSB first) and increments bit counter (width clog2(WordBits)+1).
- On sclk_rise that completes bit WordBits: word = shifted value, RS captured in same cycle, counter wraps to 0; stay in SHIFT (continuous CS-low streaming supported, words delimited by count only).
- CS rising with counter 1..WordBits-1: partial word discarded, FrameErr set, counter cleared. Counter 0: no error.
- sclk_rise while in IDLE ignored.
- Output register (no FIFO): completed word loaded if RxValid=0, or RxValid=1 and RxReady=1 same cycle (pop and load simultaneously, no overrun). Otherwise word dropped, Overrun set, held word unchanged.
- RxValid clears on RxValid&RxReady without a simultaneous load.
- ClrErr clears both sticky flags; if an error event coincides with ClrErr, the flag stays set.

## Timing
- Requirement: MasterCLK ≥ 4× SPI_CLK; SPI_CLK high and low each ≥ 2 MasterCLK periods. MOSI/RS stable around rising SPI_CLK by ≥ 1 MasterCLK period.
- Latency: RxValid rises SyncStages+2 MasterCLK cycles after the raw SPI_CLK rising edge carrying the last bit.
- Throughput: one word per WordBits SPI_CLK periods, no dead bits between words.
- Reset (RSTn low, any time incl. mid-word): RxData=0, RxRS=0, RxValid=0, Overrun=0, FrameErr=0, counter=0, state IDLE, FIFO empty. After release the first word starts at the next synchronized CS falling edge; a CS already low at release is not treated as a falling edge.

## Configuration
- TFT_RX_FIFO_EN defined: completed words go to a FifoDepth-entry FIFO; RxData/RxRS/RxValid show the head (first-word fall-through). Push when full without a same-cycle pop → word dropped, Overrun set. Pop and push on full in the same cycle both succeed.
- Not defined: single output register exactly as in Operation; FifoDepth ignored.

## Test plan
- Reset, CS low, send 16'hA5C3 with RS=1, RxReady=1 → one RxValid pulse, RxData=A5C3, RxRS=1, latency SyncStages+2 cycles after 16th edge.
- CS held low, stream 16'h002A (RS=0) then 16'h1234 (RS=1) back-to-back → two words in order with RS 0 then 1, no FrameErr.
- RxReady=0, send 3 words (no FIFO) → first word held, Overrun=1 after second; with TFT_RX_FIFO_EN, 5 words into depth 4 → 4 words drained in order, Overrun=1.
- CS rises after 7 bits, then full word 16'hFFFF → FrameErr=1, only FFFF delivered; ClrErr pulse → FrameErr=0.
- Assert RSTn low mid-word at bit 9, release, send 16'h0F0F → only 0F0F delivered, all flags 0.
- Word completes in the same cycle as RxValid&RxReady pop → new word loaded, Overrun stays 0.
